// File: rtl/rob_order_manager_pkg.sv
// Shared definitions for the ROB-based order manager: tag sizing, the
// "value is in the register file" tag, and the ROB entry layout.
package om_pkg;

    localparam int TAG_NONE = 0;

    localparam int OM_XLEN   = 32;
    localparam int OM_RIDX_W = 5;

    function automatic int om_tag_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Entry layout at the default geometry; the top derives its own from its parameters.
    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 has_rd;
        logic [OM_RIDX_W-1:0] rd;
        logic [OM_XLEN-1:0]   value;
    } rob_entry_t;

endpackage

// File: rtl/rob_order_manager_rename_map.sv
// Register rename table: architectural register -> producing ROB tag (0 = in
// register file). Dispatch write beats a same-cycle commit clear.
module rob_rename_map
    import om_pkg::*;
#(
    parameter  int NREG   = 32,
    parameter  int TAG_W  = 4,
    localparam int RIDX_W = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [RIDX_W-1:0] rs1_i,
    input  logic [RIDX_W-1:0] rs2_i,
    output logic [TAG_W-1:0]  tag1_o,
    output logic [TAG_W-1:0]  tag2_o,
    input  logic              wr_en_i,
    input  logic [RIDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              clr_en_i,
    input  logic [RIDX_W-1:0] clr_idx_i,
    input  logic [TAG_W-1:0]  clr_tag_i
);

    logic [TAG_W-1:0] map_q [NREG];
    logic [TAG_W-1:0] map_d [NREG];

    assign tag1_o = map_q[rs1_i];
    assign tag2_o = map_q[rs2_i];

    always_comb begin
        map_d = map_q;
        if (flush_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                map_d[i] = TAG_W'(TAG_NONE);
            end
        end else begin
            // Clear only if no younger producer has since claimed the register.
            if (clr_en_i && (map_q[clr_idx_i] == clr_tag_i)) begin
                map_d[clr_idx_i] = TAG_W'(TAG_NONE);
            end
            if (wr_en_i) begin
                map_d[wr_idx_i] = wr_tag_i;
            end
        end
        map_d[0] = TAG_W'(TAG_NONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                map_q[i] <= '0;
            end
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: rtl/rob_order_manager.sv
// Circular reorder buffer with rename map, multi-channel CDB capture, operand
// forwarding from completed entries, in-order single-wide commit and flush.
module rob_order_manager
    import om_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NREG      = 32,
    parameter  int ROB_DEPTH = 8,
    parameter  int NUM_CDB   = 6,
    localparam int TAG_W     = om_tag_w(ROB_DEPTH),
    localparam int RIDX_W    = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic                     disp_has_rd,
    input  logic [RIDX_W-1:0]        disp_rd,
    input  logic [RIDX_W-1:0]        disp_rs1,
    input  logic [RIDX_W-1:0]        disp_rs2,
    output logic [TAG_W-1:0]         disp_tag,
    output logic [TAG_W-1:0]         qj,
    output logic [TAG_W-1:0]         qk,
    output logic                     vj_fwd,
    output logic [XLEN-1:0]          vj_data,
    output logic                     vk_fwd,
    output logic [XLEN-1:0]          vk_data,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    output logic                     commit_wen,
    output logic [RIDX_W-1:0]        commit_idx,
    output logic [XLEN-1:0]          commit_data,
    output logic                     retire,
    output logic [TAG_W-1:0]         rob_count
);

    localparam int PTR_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_rd;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   value;
    } entry_t;

    entry_t           rob_q [ROB_DEPTH];
    entry_t           rob_d [ROB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [TAG_W-1:0] count_q, count_d;

    logic [TAG_W-1:0] cdb_tag_w  [NUM_CDB];
    logic [XLEN-1:0]  cdb_data_w [NUM_CDB];

    logic [RIDX_W-1:0] src_idx  [2];
    logic [TAG_W-1:0]  src_map  [2];
    logic [TAG_W-1:0]  src_q    [2];
    logic              src_fwd  [2];
    logic [XLEN-1:0]   src_data [2];

    logic [TAG_W-1:0] map_tag1, map_tag2;
    logic             disp_fire;
    logic             has_rd_eff;
    entry_t           head_e;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ROB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [TAG_W-1:0] ptr_to_tag(input logic [PTR_W-1:0] p);
        return TAG_W'(p) + TAG_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] tag_to_ptr(input logic [TAG_W-1:0] t);
        return PTR_W'(t - TAG_W'(1));
    endfunction

    function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
        return (t != TAG_W'(TAG_NONE)) && (t <= TAG_W'(ROB_DEPTH));
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            cdb_tag_w[k]  = cdb_tag[k*TAG_W +: TAG_W];
            cdb_data_w[k] = cdb_data[k*XLEN +: XLEN];
        end
    end

    assign disp_ready = (count_q != TAG_W'(ROB_DEPTH)) && !flush;
    assign disp_fire  = disp_valid && disp_ready;
    assign has_rd_eff = disp_has_rd && (disp_rd != '0);
    assign disp_tag   = ptr_to_tag(tail_q);
    assign rob_count  = count_q;

    assign head_e      = rob_q[head_q];
    assign retire      = head_e.valid && head_e.done && !flush;
    assign commit_wen  = retire && head_e.has_rd;
    assign commit_idx  = head_e.rd;
    assign commit_data = head_e.value;

    rob_rename_map #(
        .NREG  (NREG),
        .TAG_W (TAG_W)
    ) u_map (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .flush_i   (flush),
        .rs1_i     (disp_rs1),
        .rs2_i     (disp_rs2),
        .tag1_o    (map_tag1),
        .tag2_o    (map_tag2),
        .wr_en_i   (disp_fire && has_rd_eff),
        .wr_idx_i  (disp_rd),
        .wr_tag_i  (disp_tag),
        .clr_en_i  (commit_wen),
        .clr_idx_i (head_e.rd),
        .clr_tag_i (ptr_to_tag(head_q))
    );

    assign src_idx[0] = disp_rs1;
    assign src_idx[1] = disp_rs2;
    assign src_map[0] = map_tag1;
    assign src_map[1] = map_tag2;

    // Source lookup sees the map before this cycle's dispatch write.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            src_q[s]    = TAG_W'(TAG_NONE);
            src_fwd[s]  = 1'b0;
            src_data[s] = '0;
            if ((src_idx[s] != '0) && (src_map[s] != TAG_W'(TAG_NONE))) begin
                if (rob_q[tag_to_ptr(src_map[s])].done) begin
                    src_fwd[s]  = 1'b1;
                    src_data[s] = rob_q[tag_to_ptr(src_map[s])].value;
                end else begin
                    src_q[s] = src_map[s];
                    // Descending scan so the lowest matching channel wins.
                    for (int unsigned k = NUM_CDB; k > 0; k--) begin
                        if (cdb_valid[k-1] && (cdb_tag_w[k-1] == src_map[s])) begin
                            src_q[s]    = TAG_W'(TAG_NONE);
                            src_fwd[s]  = 1'b1;
                            src_data[s] = cdb_data_w[k-1];
                        end
                    end
                end
            end
        end
    end

    assign qj      = src_q[0];
    assign vj_fwd  = src_fwd[0];
    assign vj_data = src_data[0];
    assign qk      = src_q[1];
    assign vk_fwd  = src_fwd[1];
    assign vk_data = src_data[1];

    always_comb begin
        rob_d   = rob_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                rob_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int unsigned k = NUM_CDB; k > 0; k--) begin
                if (cdb_valid[k-1] && tag_in_range(cdb_tag_w[k-1]) &&
                    rob_q[tag_to_ptr(cdb_tag_w[k-1])].valid &&
                    !rob_q[tag_to_ptr(cdb_tag_w[k-1])].done) begin
                    rob_d[tag_to_ptr(cdb_tag_w[k-1])].done  = 1'b1;
                    rob_d[tag_to_ptr(cdb_tag_w[k-1])].value = cdb_data_w[k-1];
                end
            end
            if (retire) begin
                rob_d[head_q] = '0;
                head_d        = wrap_inc(head_q);
            end
            if (disp_fire) begin
                rob_d[tail_q] = '{valid: 1'b1, done: 1'b0, has_rd: has_rd_eff,
                                  rd: disp_rd, value: '0};
                tail_d        = wrap_inc(tail_q);
            end
            count_d = count_q + TAG_W'(disp_fire) - TAG_W'(retire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            rob_q   <= rob_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rob_order_manager.sv
// Self-checking bench for rob_order_manager: directed scenarios plus a random
// run against a queue-based model of the in-flight instruction window.
module tb_rob_order_manager;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int DEPTH = 8;
    localparam int NCDB  = 6;
    localparam int TW    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush, disp_valid, disp_has_rd;
    logic [4:0]        disp_rd, disp_rs1, disp_rs2;
    logic [NCDB-1:0]      cdb_valid;
    logic [NCDB*TW-1:0]   cdb_tag;
    logic [NCDB*XLEN-1:0] cdb_data;

    logic            disp_ready, vj_fwd, vk_fwd, commit_wen, retire;
    logic [TW-1:0]   disp_tag, qj, qk, rob_count;
    logic [XLEN-1:0] vj_data, vk_data, commit_data;
    logic [4:0]      commit_idx;

    int checks = 0;
    int errors = 0;

    rob_order_manager #(
        .XLEN      (XLEN),
        .NREG      (NREG),
        .ROB_DEPTH (DEPTH),
        .NUM_CDB   (NCDB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_has_rd (disp_has_rd),
        .disp_rd     (disp_rd),
        .disp_rs1    (disp_rs1),
        .disp_rs2    (disp_rs2),
        .disp_tag    (disp_tag),
        .qj          (qj),
        .qk          (qk),
        .vj_fwd      (vj_fwd),
        .vj_data     (vj_data),
        .vk_fwd      (vk_fwd),
        .vk_data     (vk_data),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .commit_wen  (commit_wen),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .retire      (retire),
        .rob_count   (rob_count)
    );

    always #5 clk = ~clk;

    // Model: program-ordered list of in-flight instructions.
    typedef struct {
        int          tag;
        int          rd;
        bit          has_rd;
        bit          done;
        logic [31:0] val;
    } minst_t;

    minst_t mq[$];
    int     m_tail = 0;

    function automatic void m_reset();
        mq.delete();
        m_tail = 0;
    endfunction

    // Youngest in-flight writer of r names the pending tag.
    function automatic int m_map(input int r);
        if (r == 0) return 0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].has_rd && mq[i].rd == r) return mq[i].tag;
        end
        return 0;
    endfunction

    function automatic void m_src(input int rs, output int q, output bit fwd,
                                  output logic [31:0] d);
        int t;
        q = 0; fwd = 0; d = '0;
        t = m_map(rs);
        if (t == 0) return;
        foreach (mq[i]) begin
            if (mq[i].tag == t && mq[i].done) begin
                fwd = 1; d = mq[i].val; return;
            end
        end
        for (int ch = 0; ch < NCDB; ch++) begin
            if (cdb_valid[ch] && cdb_tag[ch*TW +: TW] == TW'(t)) begin
                fwd = 1; d = cdb_data[ch*XLEN +: XLEN]; return;
            end
        end
        q = t;
    endfunction

    function automatic void m_step();
        bit     ret, fire;
        minst_t e;
        if (flush) begin
            m_reset();
            return;
        end
        ret  = (mq.size() > 0) && mq[0].done;
        fire = disp_valid && (mq.size() < DEPTH);
        foreach (mq[i]) begin
            if (!mq[i].done) begin
                for (int ch = 0; ch < NCDB; ch++) begin
                    if (cdb_valid[ch] && cdb_tag[ch*TW +: TW] == TW'(mq[i].tag)) begin
                        mq[i].done = 1;
                        mq[i].val  = cdb_data[ch*XLEN +: XLEN];
                        break;
                    end
                end
            end
        end
        if (ret) void'(mq.pop_front());
        if (fire) begin
            e.tag = m_tail + 1; e.rd = int'(disp_rd);
            e.has_rd = disp_has_rd && (disp_rd != 0);
            e.done = 0; e.val = '0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endfunction

    task automatic drive_idle();
        flush = 0; disp_valid = 0; disp_has_rd = 0;
        disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_cdb(input int ch, input int tag, input logic [31:0] d);
        cdb_valid[ch]            = 1'b1;
        cdb_tag[ch*TW +: TW]     = TW'(tag);
        cdb_data[ch*XLEN +: XLEN] = d;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic dispatch(input int rd);
        disp_valid = 1; disp_has_rd = 1; disp_rd = 5'(rd);
        tick();
        disp_valid = 0; disp_has_rd = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst_n = 0;
        disp_valid = 1; disp_rs1 = 5; disp_rs2 = 9;
        #1;
        checks++; if (rob_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rob_count); end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", disp_ready); end
        checks++; if ({retire, commit_wen} !== 2'b00) begin errors++; $display("FAIL reset_commit: retire/wen got %b expected 00", {retire, commit_wen}); end
        checks++; if ({qj, qk, vj_fwd, vk_fwd} !== '0) begin errors++; $display("FAIL reset_src: qj=%0d qk=%0d fwd=%b%b expected all 0", qj, qk, vj_fwd, vk_fwd); end
        checks++; if (disp_tag !== 4'd1) begin errors++; $display("FAIL reset_tag: got %0d expected 1", disp_tag); end
        do_reset();
    endtask

    task automatic test_dispatch_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp_valid = 1; disp_has_rd = 1; disp_rd = 5'(5 + i);
            #1;
            checks++; if (disp_tag !== TW'(i + 1)) begin errors++; $display("FAIL basic_tag%0d: got %0d expected %0d", i, disp_tag, i + 1); end
            tick();
        end
        disp_valid = 0; disp_rs1 = 5; disp_rs2 = 7;
        #1;
        checks++; if (rob_count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", rob_count); end
        checks++; if (qj !== 4'd1 || vj_fwd !== 1'b0) begin errors++; $display("FAIL basic_qj: got qj=%0d fwd=%b expected 1/0", qj, vj_fwd); end
        checks++; if (qk !== 4'd3) begin errors++; $display("FAIL basic_qk: got %0d expected 3", qk); end
    endtask

    task automatic test_full_commit();
        do_reset();
        for (int i = 0; i < DEPTH; i++) dispatch(i + 1);
        disp_valid = 1; disp_has_rd = 1; disp_rd = 20;
        #1;
        checks++; if (rob_count !== 4'd8 || disp_ready !== 1'b0) begin errors++; $display("FAIL full_ready: count=%0d ready=%b expected 8/0", rob_count, disp_ready); end
        tick();
        disp_valid = 0;
        set_cdb(2, 1, 32'hDEAD);
        tick();
        drive_idle();
        #1;
        checks++; if ({retire, commit_wen} !== 2'b11 || commit_idx !== 5'd1 || commit_data !== 32'hDEAD) begin
            errors++; $display("FAIL full_commit: ret/wen=%b idx=%0d data=%h expected 11/1/0000dead", {retire, commit_wen}, commit_idx, commit_data); end
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_no_recycle: ready got %b expected 0", disp_ready); end
        tick();
        checks++; if (rob_count !== 4'd7 || disp_ready !== 1'b1) begin errors++; $display("FAIL full_after: count=%0d ready=%b expected 7/1", rob_count, disp_ready); end
    endtask

    task automatic test_rename_hazard();
        do_reset();
        dispatch(4);
        dispatch(4);
        set_cdb(0, 1, 32'd111);
        tick();
        drive_idle();
        tick();
        disp_rs1 = 4;
        #1;
        checks++; if (qj !== 4'd2 || vj_fwd !== 1'b0) begin errors++; $display("FAIL hazard_map: qj=%0d fwd=%b expected 2/0", qj, vj_fwd); end
        set_cdb(1, 2, 32'd222);
        #1;
        checks++; if (qj !== 4'd0 || vj_fwd !== 1'b1 || vj_data !== 32'd222) begin errors++; $display("FAIL hazard_cdbfwd: qj=%0d fwd=%b data=%0d expected 0/1/222", qj, vj_fwd, vj_data); end
        tick();
        cdb_valid = '0;
        #1;
        checks++; if (commit_wen !== 1'b1 || commit_idx !== 5'd4 || commit_data !== 32'd222) begin errors++; $display("FAIL hazard_commit2: wen=%b idx=%0d data=%0d expected 1/4/222", commit_wen, commit_idx, commit_data); end
        tick();
        checks++; if (qj !== 4'd0 || vj_fwd !== 1'b0 || rob_count !== 4'd0) begin errors++; $display("FAIL hazard_clear: qj=%0d fwd=%b count=%0d expected 0/0/0", qj, vj_fwd, rob_count); end
    endtask

    task automatic test_forwarding();
        do_reset();
        for (int i = 1; i <= 4; i++) dispatch(i);
        set_cdb(3, 3, 32'hC0FFEE03);
        tick();
        drive_idle();
        disp_rs2 = 3;
        #1;
        checks++; if (qk !== 4'd0 || vk_fwd !== 1'b1 || vk_data !== 32'hC0FFEE03) begin errors++; $display("FAIL fwd_done: qk=%0d fwd=%b data=%h expected 0/1/c0ffee03", qk, vk_fwd, vk_data); end
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL fwd_noretire: got %b expected 0", retire); end
        set_cdb(0, 4, 32'hAAAA0000);
        set_cdb(5, 4, 32'hBBBB5555);
        disp_rs1 = 4;
        #1;
        checks++; if (qj !== 4'd0 || vj_fwd !== 1'b1 || vj_data !== 32'hAAAA0000) begin errors++; $display("FAIL fwd_cdb_prio: qj=%0d fwd=%b data=%h expected 0/1/aaaa0000", qj, vj_fwd, vj_data); end
        tick();
        cdb_valid = '0;
        #1;
        checks++; if (vj_fwd !== 1'b1 || vj_data !== 32'hAAAA0000) begin errors++; $display("FAIL fwd_captured: fwd=%b data=%h expected 1/aaaa0000", vj_fwd, vj_data); end
    endtask

    task automatic test_wraparound();
        int          rd;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            rd = $urandom_range(1, 31);
            d  = $urandom;
            disp_valid = 1; disp_has_rd = 1; disp_rd = 5'(rd);
            #1;
            checks++; if (disp_tag !== TW'((i % DEPTH) + 1)) begin errors++; $display("FAIL wrap_tag%0d: got %0d expected %0d", i, disp_tag, (i % DEPTH) + 1); end
            tick();
            drive_idle();
            set_cdb($urandom_range(0, NCDB - 1), (i % DEPTH) + 1, d);
            tick();
            drive_idle();
            #1;
            checks++; if ({retire, commit_wen} !== 2'b11 || commit_idx !== 5'(rd) || commit_data !== d) begin
                errors++; $display("FAIL wrap_commit%0d: ret/wen=%b idx=%0d data=%h expected 11/%0d/%h", i, {retire, commit_wen}, commit_idx, commit_data, rd, d); end
            tick();
        end
        checks++; if (rob_count !== 4'd0) begin errors++; $display("FAIL wrap_empty: count=%0d expected 0", rob_count); end
    endtask

    task automatic test_flush();
        int bad;
        do_reset();
        for (int i = 1; i <= 5; i++) dispatch(i);
        set_cdb(1, 1, 32'h1111);
        tick();
        drive_idle();
        flush = 1; disp_valid = 1; disp_has_rd = 1; disp_rd = 9;
        set_cdb(0, 2, 32'h2222);
        #1;
        checks++; if ({retire, commit_wen, disp_ready} !== 3'b000) begin errors++; $display("FAIL flush_suppress: ret/wen/ready=%b expected 000", {retire, commit_wen, disp_ready}); end
        tick();
        drive_idle();
        #1;
        checks++; if (rob_count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", rob_count); end
        bad = 0;
        for (int r = 0; r < NREG; r++) begin
            disp_rs1 = 5'(r); disp_rs2 = 5'(r);
            #1;
            if ({qj, qk, vj_fwd, vk_fwd} !== '0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL flush_map: %0d registers still pending, expected 0", bad); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 3; i++) dispatch(i);
        set_cdb(4, 1, 32'h77);
        tick();
        drive_idle();
        disp_rs1 = 2;
        #1;
        checks++; if (retire !== 1'b1 || qj !== 4'd2) begin errors++; $display("FAIL areset_pre: retire=%b qj=%0d expected 1/2", retire, qj); end
        @(negedge clk);
        rst_n = 0;
        m_reset();
        #1;
        checks++; if (rob_count !== 4'd0 || {retire, commit_wen} !== 2'b00 || disp_ready !== 1'b1) begin
            errors++; $display("FAIL areset_state: count=%0d ret/wen=%b ready=%b expected 0/00/1", rob_count, {retire, commit_wen}, disp_ready); end
        checks++; if (qj !== 4'd0 || vj_fwd !== 1'b0 || disp_tag !== 4'd1) begin errors++; $display("FAIL areset_map: qj=%0d fwd=%b tag=%0d expected 0/0/1", qj, vj_fwd, disp_tag); end
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_random();
        int          eq, ek, pick;
        bit          ef, ekf;
        logic [31:0] ed, ekd;
        bit          eret, ewen;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive_idle();
            flush       = ($urandom_range(0, 49) == 0);
            disp_valid  = ($urandom_range(0, 9) < 7);
            disp_has_rd = ($urandom_range(0, 3) != 0);
            disp_rd     = 5'($urandom);
            disp_rs1    = 5'($urandom);
            disp_rs2    = 5'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, mq.size() - 1);
                disp_rs1 = 5'(mq[pick].rd);
                pick = $urandom_range(0, mq.size() - 1);
                disp_rs2 = 5'(mq[pick].rd);
            end
            for (int ch = 0; ch < NCDB; ch++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                        set_cdb(ch, mq[$urandom_range(0, mq.size() - 1)].tag, $urandom);
                    else
                        set_cdb(ch, $urandom_range(0, 15), $urandom);
                end
            end
            #1;
            m_src(int'(disp_rs1), eq, ef, ed);
            m_src(int'(disp_rs2), ek, ekf, ekd);
            eret = !flush && (mq.size() > 0) && mq[0].done;
            ewen = eret && mq[0].has_rd;
            checks++; if (disp_ready !== (!flush && mq.size() < DEPTH) || disp_tag !== TW'(m_tail + 1) || rob_count !== TW'(mq.size())) begin
                errors++; $display("FAIL rand_alloc c%0d: ready=%b tag=%0d count=%0d expected %b/%0d/%0d", cyc, disp_ready, disp_tag, rob_count, (!flush && mq.size() < DEPTH), m_tail + 1, mq.size()); end
            checks++; if (qj !== TW'(eq) || vj_fwd !== ef || (ef && vj_data !== ed)) begin
                errors++; $display("FAIL rand_src1 c%0d: qj=%0d fwd=%b data=%h expected %0d/%b/%h", cyc, qj, vj_fwd, vj_data, eq, ef, ed); end
            checks++; if (qk !== TW'(ek) || vk_fwd !== ekf || (ekf && vk_data !== ekd)) begin
                errors++; $display("FAIL rand_src2 c%0d: qk=%0d fwd=%b data=%h expected %0d/%b/%h", cyc, qk, vk_fwd, vk_data, ek, ekf, ekd); end
            checks++; if (retire !== eret || commit_wen !== ewen || (ewen && (commit_idx !== 5'(mq[0].rd) || commit_data !== mq[0].val))) begin
                errors++; $display("FAIL rand_commit c%0d: ret=%b wen=%b idx=%0d data=%h expected ret=%b wen=%b", cyc, retire, commit_wen, commit_idx, commit_data, eret, ewen); end
            tick();
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_dispatch_basic();
        test_full_commit();
        test_rename_hazard();
        test_forwarding();
        test_wraparound();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_order_manager.md
Name: rob_order_manager

Overview:
- Parametrised successor to the order manager.
- Combines a circular reorder buffer (ROB) and a register rename map, with dispatch handshake, multi-channel CDB capture, operand forwarding from completed ROB entries, in-order single-wide commit and full flush.
- Sits between decoder/issue logic, the reservation stations and the register file.
- Tags are ROB-based:
  - tag 0 = value in register file.
  - tag k (1..ROB_DEPTH) = ROB entry k-1.

Parameters:
XLEN, 32, data width
NREG, 32, architectural registers (x0 hardwired zero)
ROB_DEPTH, 8, ROB entries (>=2)
NUM_CDB, 6, CDB broadcast channels
TAG_W, $clog2(ROB_DEPTH+1), tag width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all in-flight state
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available: !full && !flush
disp_has_rd  in  1  instruction writes rd
disp_rd  in  $clog2(NREG)  destination register
disp_rs1  in  $clog2(NREG)  source 1
disp_rs2  in  $clog2(NREG)  source 2
disp_tag  out  TAG_W  tag allocated to this dispatch (tail+1)
qj  out  TAG_W  pending tag for rs1, 0 if value available
qk  out  TAG_W  pending tag for rs2
vj_fwd  out  1  rs1 value supplied from ROB/CDB in vj_data
vj_data  out  XLEN  forwarded rs1 value
vk_fwd  out  1  rs2 counterpart
vk_data  out  XLEN  forwarded rs2 value
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  per-channel tag, channel i at [i*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*XLEN  per-channel result
commit_wen  out  1  register file write enable
commit_idx  out  $clog2(NREG)  register file write index
commit_data  out  XLEN  register file write data
retire  out  1  head entry leaves ROB this cycle (with or without rd)
rob_count  out  $clog2(ROB_DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst_n=0):
  - head=tail=0, rob_count=0, all entry valid/done cleared, rename map all 0.
  - Outputs after reset: commit_wen=0, retire=0, disp_ready=1, qj=qk=0, vj_fwd=vk_fwd=0.
  - Reset mid-operation discards everything.
- Dispatch fires when disp_valid && disp_ready. Same edge:
  - Entry[tail] gets valid=1, done=0, rd, has_rd = disp_has_rd && disp_rd!=0.
  - tail advances, wrapping ROB_DEPTH-1 -> 0.
  - If has_rd, map[rd] = tail+1.
- Full/empty:
  - disp_ready=0 when rob_count==ROB_DEPTH, even if retiring the same cycle; no same-cycle slot recycling.
  - Empty ROB: retire=0.
- Source lookup is combinational and uses the map before this cycle's update, so rd==rs1 yields the older producer. For each source:
  - Index 0 or map entry 0 -> q=0, fwd=0.
  - Else, if the mapped entry has done=1 -> q=0, fwd=1, data=entry value.
  - Else, if any CDB channel broadcasts that tag this cycle -> q=0, fwd=1, data=CDB data, lowest channel wins.
  - Otherwise q=mapped tag, fwd=0.
- CDB capture, at the clock edge, per channel:
  - Tag must be nonzero and name a valid, not-done entry; then set done=1 and store data.
  - Several channels with the same tag: lowest index wins.
  - Invalid or stale tags are ignored.
- Commit:
  - retire = entry[head].valid && entry[head].done && !flush.
  - commit_wen = retire && entry[head].has_rd.
  - commit_idx and commit_data come from the head entry.
  - All three depend on registered state only.
  - On retire: head advances with wrap, entry cleared, and map[rd] reset to 0 only if map[rd]==head+1.
  - Same-cycle dispatch to the same rd wins over the commit clear.
- rob_count updates by +dispatch -retire. Simultaneous dispatch and retire leaves it unchanged.
- A CDB write to an entry at head in cycle N makes it retire in cycle N+1 (1-cycle latency).
- flush:
  - Synchronous, highest priority.
  - Clears all entries, pointers, count and map at the next edge.
  - Dispatch, CDB and retire are suppressed in the flush cycle.

Decomposition:
- Package om_pkg:
  - Tag-width function.
  - TAG_NONE=0.
  - ROB entry struct {valid, done, has_rd, rd, value}.
- Sub-module rob_rename_map:
  - NREG x TAG_W table.
  - Two combinational lookups, one write port for dispatch.
  - Conditional clear port for commit; write has priority over clear.
  - Synchronous flush.

Test Plan:
- Reset, then dispatch 3 instructions with rd=5,6,7 -> disp_tag=1,2,3; rob_count=3; dispatch rs1=5 gives qj=1.
- Fill 8 entries -> disp_ready=0 at count 8. Broadcast tag 1 on channel 2, data 0xDEAD -> next cycle commit_wen=1, idx=rd of entry 0, data 0xDEAD; count 7; disp_ready=1 in the following cycle.
- Rename hazard: dispatch rd=4 (tag1), then rd=4 (tag2), complete and retire tag1 -> map[4] stays 2; retire tag2 -> map[4]=0.
- Forwarding: tag 3 done but not at head, dispatch rs2 -> qk=0, vk_fwd=1 with stored value. Same-cycle CDB tag 4 on channels 0 and 5 with different data -> channel 0 data forwarded and captured.
- Wrap-around: 20 dispatch/complete/retire pairs with ROB_DEPTH=8 -> tags cycle 1..8, commits strictly in dispatch order.
- flush with 5 entries in flight and CDB active -> no commit that cycle; next cycle count=0, qj=qk=0 for all registers. Assert rst_n mid-stream -> identical cleared state immediately.
